mem_arbiter: RTL and testbench

Arbitrates and sequences accesses to the single-port unified instruction/data RAM (N-bit word address, M-bit words, combinational read, synchronous write) between the instruction-fetch unit and the load/store unit. Data requests take priority, with a starvation limit that protects instruction fetch. Doubleword (2·M-bit) data accesses are split into two consecutive RAM beats. The block sits between the core's memory-stage and fetch-stage ports and the RAM instance.

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified RAM between instruction fetch
// and the load/store unit. Data requests win by default; a starvation counter
// forces a fetch grant after STARVE_LIMIT consecutive data grants made while
// fetch was waiting. Doubleword data accesses are issued as two RAM beats.
module mem_arbiter #(
  parameter int N            = 20,
  parameter int M            = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_req_valid,
  output logic           if_req_ready,
  input  logic [N-1:0]   if_req_addr,
  output logic           if_rsp_valid,
  output logic [M-1:0]   if_rsp_data,
  input  logic           d_req_valid,
  output logic           d_req_ready,
  input  logic           d_req_we,
  input  logic           d_req_dword,
  input  logic [N-1:0]   d_req_addr,
  input  logic [2*M-1:0] d_req_wdata,
  output logic           d_rsp_valid,
  output logic [2*M-1:0] d_rsp_rdata,
  output logic           ram_we,
  output logic [N-1:0]   ram_addr,
  output logic [M-1:0]   ram_din,
  input  logic [M-1:0]   ram_dout
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t         state_q, state_d;
  logic           own_d_q, own_d_d;       // 1 = transaction belongs to data port
  logic           we_q, we_d;
  logic           dword_q, dword_d;
  logic [N-1:0]   addr_q, addr_d;
  logic [2*M-1:0] wdata_q, wdata_d;
  logic [M-1:0]   res_lo_q, res_lo_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           ram_we_q, ram_we_d;
  logic [N-1:0]   ram_addr_q, ram_addr_d;
  logic [M-1:0]   ram_din_q, ram_din_d;
  logic           if_rsp_valid_q, if_rsp_valid_d;
  logic [M-1:0]   if_rsp_data_q, if_rsp_data_d;
  logic           d_rsp_valid_q, d_rsp_valid_d;
  logic [2*M-1:0] d_rsp_rdata_q, d_rsp_rdata_d;
  logic           starved;
  logic           hs_d, hs_if;

  assign starved = (starve_q == SW'(STARVE_LIMIT));

  // Grant: data wins unless fetch is alone or fetch has been starved too long
  always_comb begin
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    if (state_q == IDLE) begin
      if (d_req_valid && !(if_req_valid && starved)) d_req_ready = 1'b1;
      else if (if_req_valid)                         if_req_ready = 1'b1;
    end
  end

  assign hs_d  = d_req_valid  & d_req_ready;
  assign hs_if = if_req_valid & if_req_ready;

  // Next-state and next-output computation; RAM controls are registered so
  // they line up with the BEAT0/BEAT1 cycles and never depend on ram_dout
  always_comb begin
    state_d        = state_q;
    own_d_d        = own_d_q;
    we_d           = we_q;
    dword_d        = dword_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    res_lo_d       = res_lo_q;
    starve_d       = starve_q;
    ram_we_d       = 1'b0;
    ram_addr_d     = addr_q;
    ram_din_d      = '0;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    d_rsp_valid_d  = 1'b0;
    d_rsp_rdata_d  = d_rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (hs_d) begin
          own_d_d    = 1'b1;
          we_d       = d_req_we;
          dword_d    = d_req_dword;
          addr_d     = d_req_addr;
          wdata_d    = d_req_wdata;
          ram_we_d   = d_req_we;
          ram_addr_d = d_req_addr;
          ram_din_d  = d_req_wdata[M-1:0];
          state_d    = BEAT0;
          if (if_req_valid && !starved) starve_d = starve_q + SW'(1);
        end else if (hs_if) begin
          own_d_d    = 1'b0;
          we_d       = 1'b0;
          dword_d    = 1'b0;
          addr_d     = if_req_addr;
          wdata_d    = '0;
          ram_addr_d = if_req_addr;
          state_d    = BEAT0;
          starve_d   = '0;
        end
      end
      BEAT0: begin
        if (dword_q) begin
          res_lo_d   = we_q ? '0 : ram_dout;
          ram_we_d   = we_q;
          ram_addr_d = addr_q + N'(1);
          ram_din_d  = wdata_q[2*M-1:M];
          state_d    = BEAT1;
        end else begin
          if (own_d_q) begin
            d_rsp_valid_d = 1'b1;
            d_rsp_rdata_d = we_q ? '0 : {{M{1'b0}}, ram_dout};
          end else begin
            if_rsp_valid_d = 1'b1;
            if_rsp_data_d  = ram_dout;
          end
          state_d = RESP;
        end
      end
      BEAT1: begin
        d_rsp_valid_d = 1'b1;
        d_rsp_rdata_d = we_q ? '0 : {ram_dout, res_lo_q};
        state_d       = RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and all port-visible registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      own_d_q        <= 1'b0;
      we_q           <= 1'b0;
      dword_q        <= 1'b0;
      addr_q         <= '0;
      starve_q       <= '0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_din_q      <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_rdata_q  <= '0;
    end else begin
      state_q        <= state_d;
      own_d_q        <= own_d_d;
      we_q           <= we_d;
      dword_q        <= dword_d;
      addr_q         <= addr_d;
      starve_q       <= starve_d;
      ram_we_q       <= ram_we_d;
      ram_addr_q     <= ram_addr_d;
      ram_din_q      <= ram_din_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      d_rsp_rdata_q  <= d_rsp_rdata_d;
    end
  end

  // Transaction payload; only read in states entered after a handshake loads it
  always_ff @(posedge clk) begin
    wdata_q  <= wdata_d;
    res_lo_q <= res_lo_d;
  end

  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_din      = ram_din_q;
  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rsp_rdata  = d_rsp_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table-driven transactions with a response
// scoreboard, plus hand-written fetch timing, starvation and reset sequences.
module tb_mem_arbiter;

  localparam int N = 20;
  localparam int M = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           if_req_valid, if_req_ready;
  logic [N-1:0]   if_req_addr;
  logic           if_rsp_valid;
  logic [M-1:0]   if_rsp_data;
  logic           d_req_valid, d_req_ready, d_req_we, d_req_dword;
  logic [N-1:0]   d_req_addr;
  logic [2*M-1:0] d_req_wdata;
  logic           d_rsp_valid;
  logic [2*M-1:0] d_rsp_rdata;
  logic           ram_we;
  logic [N-1:0]   ram_addr;
  logic [M-1:0]   ram_din, ram_dout;

  logic [M-1:0] mem [0:(1<<N)-1];

  mem_arbiter #(.N(N), .M(M), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_dword(d_req_dword), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, synchronous write
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;

  typedef struct {
    logic           is_d;
    logic           we;
    logic           dword;
    logic [N-1:0]   addr;
    logic [2*M-1:0] wdata;
    logic [2*M-1:0] exp;
  } vec_t;

  typedef struct {
    logic           is_d;
    logic [2*M-1:0] data;
    int             hs;
    int             lat;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[9];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock; sample at the falling edge and retire any response
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (if_rsp_valid && d_rsp_valid) check("both_rsp_valid", 1, 0);
    if (if_rsp_valid || d_rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {if_rsp_valid, d_rsp_valid}, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_owner", d_rsp_valid, e.is_d);
        check("rsp_data", e.is_d ? d_rsp_rdata : {32'h0, if_rsp_data}, e.data);
        check("rsp_latency", 64'(cyc - e.hs), 64'(e.lat));
      end
    end
  endtask

  task automatic do_req(input vec_t v, output int waited);
    logic [N-1:0] a1;
    int w;
    a1 = v.addr + 20'd1;
    if (v.is_d) begin
      d_req_valid = 1'b1; d_req_we = v.we; d_req_dword = v.dword;
      d_req_addr = v.addr; d_req_wdata = v.wdata;
    end else begin
      if_req_valid = 1'b1; if_req_addr = v.addr;
    end
    #1;
    w = 0;
    while (!(v.is_d ? d_req_ready : if_req_ready) && w < 20) begin
      cycle(); #1; w++;
    end
    waited = w;
    if (!(v.is_d ? d_req_ready : if_req_ready)) begin
      check("grant_timeout", 0, 1);
      d_req_valid = 1'b0; if_req_valid = 1'b0;
      return;
    end
    check("ready_exclusive", {if_req_ready, d_req_ready}, v.is_d ? 2'b01 : 2'b10);
    exp_q.push_back('{v.is_d, v.exp, cyc, v.dword ? 3 : 2});
    cycle();
    d_req_valid = 1'b0; if_req_valid = 1'b0;
    #1;
    check("beat0_addr", ram_addr, v.addr);
    check("beat0_we", ram_we, v.we);
    check("beat0_din", ram_din, v.wdata[31:0]);
    if (v.dword) begin
      cycle();
      check("beat1_addr", ram_addr, a1);
      check("beat1_we", ram_we, v.we);
      check("beat1_din", ram_din, v.wdata[63:32]);
    end
    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      cycle(); w++;
    end
    if (exp_q.size() > 0) begin
      check("rsp_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   waited;
    vec_t v;
    int   exp_is_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int   w;
    logic gd;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 20'h00010, 64'h0, 64'h00000000_DEADBEEF};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 20'h00200, 64'h11112222_33334444, 64'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 20'h00200, 64'h0, 64'h11112222_33334444};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 20'h00300, 64'h5A5A5A5A_CAFEF00D, 64'h0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 20'h00300, 64'h0, 64'h00000000_CAFEF00D};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 20'hFFFFF, 64'h0, 64'hA5A50000_12345678};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 20'h00200, 64'h0, 64'h00000000_33334444};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 20'h00201, 64'h0, 64'h00000000_11112222};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 20'h00300, 64'h0, 64'h0BADF00D_CAFEF00D};

    mem[20'h00010] = 32'hDEADBEEF;
    mem[20'hFFFFF] = 32'h12345678;
    mem[20'h00000] = 32'hA5A50000;
    mem[20'h00200] = 32'h0;
    mem[20'h00201] = 32'h0;
    mem[20'h00301] = 32'h0BADF00D;
    mem[20'h00400] = 32'h0;
    mem[20'h00401] = 32'h0;

    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_dword = 1'b0;
    d_req_addr = '0; d_req_wdata = '0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_if_ready", if_req_ready, 0);
    check("rst_d_ready", d_req_ready, 0);
    check("rst_if_rsp_valid", if_rsp_valid, 0);
    check("rst_d_rsp_valid", d_rsp_valid, 0);
    check("rst_if_rsp_data", if_rsp_data, 0);
    check("rst_d_rsp_rdata", d_rsp_rdata, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table of transactions, each followed by a hold check on response data
    for (int i = 0; i < 9; i++) begin
      do_req(tbl[i], waited);
      if (i == 0) check("fetch_alone_ready_same_cycle", waited, 0);
      cycle();
      if (tbl[i].is_d) check("d_rsp_hold", d_rsp_rdata, tbl[i].exp);
      else             check("if_rsp_hold", {32'h0, if_rsp_data}, tbl[i].exp);
    end
    check("mem_200", mem[20'h00200], 32'h33334444);
    check("mem_201", mem[20'h00201], 32'h11112222);
    check("mem_300", mem[20'h00300], 32'hCAFEF00D);
    check("mem_301_untouched", mem[20'h00301], 32'h0BADF00D);

    // Data-only grants must not advance the starvation counter
    v = tbl[4];
    for (int i = 0; i < 5; i++) do_req(v, waited);

    // Both valid continuously: four data grants, then fetch, repeating
    if_req_valid = 1'b1; if_req_addr = 20'h00010;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_dword = 1'b0;
    d_req_addr = 20'h00300; d_req_wdata = '0;
    for (int g = 0; g < 10; g++) begin
      #1;
      w = 0;
      while (!(if_req_ready || d_req_ready) && w < 10) begin
        cycle(); #1; w++;
      end
      if (!(if_req_ready || d_req_ready)) begin
        check("starve_grant_timeout", 0, 1);
        break;
      end
      check("starve_ready_exclusive", if_req_ready & d_req_ready, 0);
      gd = d_req_ready;
      check($sformatf("grant_order_%0d", g), gd, exp_is_d[g]);
      if (gd) exp_q.push_back('{1'b1, 64'h00000000_CAFEF00D, cyc, 2});
      else    exp_q.push_back('{1'b0, 64'h00000000_DEADBEEF, cyc, 2});
      cycle();
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      cycle(); w++;
    end
    check("starve_drain", exp_q.size(), 0);
    exp_q.delete();
    cycle();

    // Reset during BEAT1 of a doubleword store
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_dword = 1'b1;
    d_req_addr = 20'h00400; d_req_wdata = 64'h77777777_66666666;
    #1;
    check("rst_test_ready", d_req_ready, 1);
    cycle();
    d_req_valid = 1'b0;
    cycle();
    #1;
    check("beat1_we_before_rst", ram_we, 1);
    check("beat1_addr_before_rst", ram_addr, 20'h00401);
    rst = 1'b1;
    #1;
    check("async_rst_ram_we", ram_we, 0);
    check("async_rst_ram_addr", ram_addr, 0);
    check("async_rst_ram_din", ram_din, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("no_rsp_after_rst", d_rsp_valid, 0);
    end
    check("rst_low_word_written", mem[20'h00400], 32'h66666666);
    check("rst_high_word_untouched", mem[20'h00401], 32'h0);
    v = '{1'b1, 1'b0, 1'b0, 20'h00400, 64'h0, 64'h00000000_66666666};
    do_req(v, waited);
    check("fresh_req_after_rst", waited, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
